// File: rtl/fifo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_arbiter
// Brief    : Round-robin enqueue arbiter in front of a FIFO, plus a periodic
//            drain engine that pops one entry per tick interval.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_arbiter #(
    parameter int WIDTH         = 4,
    parameter int N_REQ         = 4,
    parameter int DRAIN_CNT_MAX = 1_250_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   fifo_enq_valid,
    output logic [WIDTH-1:0]       fifo_enq_data,
    input  logic                   fifo_enq_ready,
    input  logic                   fifo_deq_valid,
    input  logic [WIDTH-1:0]       fifo_deq_data,
    output logic                   fifo_deq_ready,
    input  logic                   drain_en,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    output logic [7:0]             drop_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (DRAIN_CNT_MAX > 1) ? $clog2(DRAIN_CNT_MAX) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CNT_MAX - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_WAIT  = 2'd2
    } drain_state_t;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] cand;
    logic             sel_found;
    logic             enq_hs;
    logic [7:0]       drop_q, drop_d;

    drain_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic             deq_hs;

    // Scan requesters starting at the priority pointer; first hit wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((32'(ptr_q) + k) % 32'(N_REQ));
            if (!sel_found && req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign enq_hs         = sel_found & fifo_enq_ready;
    assign fifo_enq_valid = |req_valid;
    assign fifo_enq_data  = sel_found ? req_data[sel_idx*WIDTH +: WIDTH] : '0;
    assign req_ready      = enq_hs ? (N_REQ'(1) << sel_idx) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (enq_hs) begin
            ptr_d = (sel_idx == PTR_LAST) ? '0 : sel_idx + 1'b1;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (fifo_enq_valid && !fifo_enq_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= '0;
            drop_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            drop_q <= drop_d;
        end
    end

    // drain_en gates the ready so a drop while waiting cannot complete a pop.
    assign fifo_deq_ready = (state_q == ST_WAIT) & drain_en;
    assign deq_hs         = fifo_deq_ready & fifo_deq_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= deq_hs;
            if (deq_hs) begin
                out_data_q <= fifo_deq_data;
            end
            if (!drain_en) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_COUNT;
                        cnt_q   <= '0;
                    end
                    ST_COUNT: begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (fifo_deq_valid) begin
                            state_q <= ST_COUNT;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fifo_arbiter
// Brief    : Self-checking bench for fifo_arbiter (WIDTH=4, N_REQ=4, MAX=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_arbiter;

    localparam int MAX   = 10;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_enq_valid;
    logic [3:0]  fifo_enq_data;
    logic        fifo_enq_ready;
    logic        fifo_deq_valid;
    logic [3:0]  fifo_deq_data;
    logic        fifo_deq_ready;
    logic        drain_en;
    logic [3:0]  out_data;
    logic        out_valid;
    logic [7:0]  drop_cnt;

    int          checks;
    int          errors;
    int          ptr_m;
    int          drop_m;
    logic [3:0]  fq[$];

    fifo_arbiter #(.WIDTH(4), .N_REQ(4), .DRAIN_CNT_MAX(MAX)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_enq_valid(fifo_enq_valid),
        .fifo_enq_data (fifo_enq_data),
        .fifo_enq_ready(fifo_enq_ready),
        .fifo_deq_valid(fifo_deq_valid),
        .fifo_deq_data (fifo_deq_data),
        .fifo_deq_ready(fifo_deq_ready),
        .drain_en      (drain_en),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle;
        req_valid      = '0;
        req_data       = '0;
        fifo_enq_ready = 1'b1;
        fifo_deq_valid = 1'b0;
        fifo_deq_data  = '0;
        drain_en       = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        ptr_m  = 0;
        drop_m = 0;
        fq.delete();
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        req_valid      = 4'hF;
        req_data       = 16'h4321;
        fifo_enq_ready = 1'b1;
        fifo_deq_valid = 1'b1;
        fifo_deq_data  = 4'hA;
        drain_en       = 1'b1;
        @(negedge clk); #1;
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 4'd0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++; if (fifo_deq_ready !== 1'b0) begin errors++; $display("FAIL reset_deq_ready: got %b expected 0", fifo_deq_ready); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr_grant: got %b expected 0001", req_ready); end
        // Release with drain_en already high: the first edge starts counting.
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if (fifo_deq_ready !== (c == MAX + 1)) begin
                errors++;
                $display("FAIL post_reset_first_tick cycle %0d: got %b expected %b", c, fifo_deq_ready, (c == MAX + 1));
            end
        end
    endtask

    task automatic test_fairness;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid      = 4'hF;
            req_data       = 16'($urandom);
            fifo_enq_ready = 1'b1;
            #1;
            checks++;
            if (req_ready !== 4'(1 << (k % 4)) || fifo_enq_data !== req_data[(k % 4) * 4 +: 4]) begin
                errors++;
                $display("FAIL fairness step %0d: got ready=%b data=%h expected ready=%b data=%h",
                         k, req_ready, fifo_enq_data, 4'(1 << (k % 4)), req_data[(k % 4) * 4 +: 4]);
            end
        end
    endtask

    task automatic test_full_stall;
        int bad;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0001;
        req_data  = 16'h0009;
        fifo_enq_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            req_valid      = 4'b0100;
            req_data       = 16'h0C00;
            fifo_enq_ready = 1'b0;
            #1;
            if (req_ready !== 4'b0000 || fifo_enq_valid !== 1'b1 || fifo_enq_data !== 4'hC) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_no_grant: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL stall_drop_saturate: got %0d expected 255", drop_cnt); end
        req_valid      = 4'hF;
        fifo_enq_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_ptr_held: got %b expected 0010", req_ready); end
    endtask

    task automatic test_drain_timing;
        do_reset();
        fq.push_back(4'd3);
        fq.push_back(4'd7);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c == 12 || c == 23)) begin
                errors++;
                $display("FAIL drain_out_valid cycle %0d: got %b expected %b", c, out_valid, (c == 12 || c == 23));
            end
            if (c == 12) begin
                checks++; if (out_data !== 4'd3) begin errors++; $display("FAIL drain_first_data: got %0d expected 3", out_data); end
            end
            if (c == 23) begin
                checks++; if (out_data !== 4'd7) begin errors++; $display("FAIL drain_second_data: got %0d expected 7", out_data); end
            end
            drain_en       = 1'b1;
            fifo_deq_valid = (fq.size() > 0);
            fifo_deq_data  = (fq.size() > 0) ? fq[0] : 4'd0;
            #1;
            checks++;
            if (fifo_deq_ready !== (c == 11 || c == 22 || c >= 33)) begin
                errors++;
                $display("FAIL drain_deq_ready cycle %0d: got %b expected %b", c, fifo_deq_ready, (c == 11 || c == 22 || c >= 33));
            end
            if (fifo_deq_ready && fifo_deq_valid) void'(fq.pop_front());
        end
    endtask

    task automatic test_empty_wait;
        do_reset();
        for (int c = 0; c < 76; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c == 62) || (c == 62 && out_data !== 4'd5)) begin
                errors++;
                $display("FAIL empty_out cycle %0d: got valid=%b data=%0d expected valid=%b data=5", c, out_valid, out_data, (c == 62));
            end
            drain_en       = 1'b1;
            req_valid      = (c == 60) ? 4'b0001 : 4'b0000;
            req_data       = 16'h0005;
            fifo_enq_ready = (fq.size() < DEPTH);
            fifo_deq_valid = (fq.size() > 0);
            fifo_deq_data  = (fq.size() > 0) ? fq[0] : 4'd0;
            #1;
            checks++;
            if (fifo_deq_ready !== ((c >= 11 && c <= 61) || c >= 72)) begin
                errors++;
                $display("FAIL empty_deq_ready cycle %0d: got %b expected %b", c, fifo_deq_ready, ((c >= 11 && c <= 61) || c >= 72));
            end
            if (c == 60) begin
                checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL empty_enq_grant: got %b expected 0001", req_ready); end
            end
            if (fifo_deq_ready && fifo_deq_valid) void'(fq.pop_front());
            if (req_ready != 4'b0000) fq.push_back(fifo_enq_data);
        end
    endtask

    task automatic test_abort;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c == 29)) begin
                errors++;
                $display("FAIL abort_out_valid cycle %0d: got %b expected %b", c, out_valid, (c == 29));
            end
            if (c >= 4) begin
                checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL abort_drop cycle %0d: got %0d expected 1", c, drop_cnt); end
            end
            if (c >= 29) begin
                checks++; if (out_data !== 4'd9) begin errors++; $display("FAIL abort_out_data cycle %0d: got %0d expected 9", c, out_data); end
            end
            drain_en       = !(c == 15 || c == 16);
            fifo_deq_valid = (c == 15 || c == 28);
            fifo_deq_data  = 4'd9;
            req_valid      = (c == 2) ? 4'b0010 : ((c == 3) ? 4'b0001 : 4'b0000);
            fifo_enq_ready = (c != 3);
            #1;
            checks++;
            if (fifo_deq_ready !== ((c >= 11 && c <= 14) || c == 28)) begin
                errors++;
                $display("FAIL abort_deq_ready cycle %0d: got %b expected %b", c, fifo_deq_ready, ((c >= 11 && c <= 14) || c == 28));
            end
        end
        // Now in COUNT with non-reset state everywhere; reset must clear it before any edge.
        req_valid      = 4'hF;
        fifo_enq_ready = 1'b1;
        rst            = 1'b1;
        #1;
        checks++;
        if (fifo_deq_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'd0 || drop_cnt !== 8'd0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL abort_async_reset: got ready=%b valid=%b data=%h drop=%0d grant=%b expected 0 0 0 0 0001",
                     fifo_deq_ready, out_valid, out_data, drop_cnt, req_ready);
        end
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_random;
        int        anchor;
        int        g;
        bit        en_prev;
        bit        hs_prev;
        bit        exp_ready;
        logic [3:0] exp_rr;
        logic [3:0] exp_data;
        logic [3:0] last_m;
        do_reset();
        anchor  = 0;
        en_prev = 1'b0;
        hs_prev = 1'b0;
        last_m  = 4'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (drop_cnt !== 8'(drop_m) || out_valid !== hs_prev || out_data !== last_m) begin
                errors++;
                $display("FAIL rand_regs cycle %0d: got drop=%0d valid=%b data=%h expected drop=%0d valid=%b data=%h",
                         c, drop_cnt, out_valid, out_data, drop_m, hs_prev, last_m);
            end
            drain_en       = ($urandom_range(0, 19) != 0);
            req_valid      = 4'($urandom);
            req_data       = 16'($urandom);
            fifo_enq_ready = (fq.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            fifo_deq_valid = (fq.size() > 0);
            fifo_deq_data  = (fq.size() > 0) ? fq[0] : 4'($urandom);

            // Ready appears MAX+1 cycles after drain_en rises or after the last pop.
            if (drain_en && !en_prev) anchor = c;
            exp_ready = drain_en && ((c - anchor) >= MAX + 1);
            g = -1;
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && req_valid[(ptr_m + k) % 4]) g = (ptr_m + k) % 4;
            end
            exp_rr   = (g >= 0 && fifo_enq_ready) ? 4'(1 << g) : 4'b0000;
            exp_data = (g >= 0) ? req_data[g * 4 +: 4] : 4'd0;
            #1;
            checks++;
            if (req_ready !== exp_rr || fifo_enq_valid !== (|req_valid) || fifo_enq_data !== exp_data) begin
                errors++;
                $display("FAIL rand_arb cycle %0d: got ready=%b valid=%b data=%h expected ready=%b valid=%b data=%h",
                         c, req_ready, fifo_enq_valid, fifo_enq_data, exp_rr, (|req_valid), exp_data);
            end
            checks++;
            if (fifo_deq_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_deq_ready cycle %0d: got %b expected %b", c, fifo_deq_ready, exp_ready);
            end

            hs_prev = exp_ready && fifo_deq_valid;
            if (hs_prev) begin
                last_m = fifo_deq_data;
                void'(fq.pop_front());
                anchor = c;
            end
            if (exp_rr != 4'b0000) begin
                fq.push_back(exp_data);
                ptr_m = (g + 1) % 4;
            end
            if ((|req_valid) && !fifo_enq_ready && drop_m < 255) drop_m++;
            en_prev = drain_en;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive_idle();
        test_reset();
        test_fairness();
        test_full_stall();
        test_drain_timing();
        test_empty_wait();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data bits per entry.
REQ-002 SHALL have parameter N_REQ, default 4, meaning number of enqueue requesters.
REQ-003 SHALL have parameter DRAIN_CNT_MAX, default 1_250_000, meaning clk cycles between dequeue attempts (0.01 s at 125 MHz).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester enqueue request.
REQ-007 SHALL have port req_data  input  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot grant; requester i's data accepted this cycle.
REQ-009 SHALL have port fifo_enq_valid / fifo_enq_data / fifo_enq_ready  output 1 / output WIDTH / input 1  FIFO enqueue port.
REQ-010 SHALL have port fifo_deq_valid / fifo_deq_data / fifo_deq_ready  input 1 / input WIDTH / output 1  FIFO dequeue port.
REQ-011 SHALL have port drain_en  input  1  enables periodic dequeue.
REQ-012 SHALL have port out_data / out_valid  output WIDTH / output 1  last dequeued entry, one-cycle strobe.
REQ-013 SHALL have port drop_cnt  output  8  saturating count of stalled request cycles.

Function
REQ-014 Enqueue arbitration SHALL be combinational round-robin: grant the first asserted req_valid at or after priority pointer ptr, wrapping modulo N_REQ.
REQ-015 fifo_enq_valid SHALL equal |req_valid; fifo_enq_data SHALL equal the selected requester's data (0 when none valid).
REQ-016 req_ready[i] SHALL be 1 only when i is selected AND fifo_enq_ready=1; at most one bit high.
REQ-017 On enqueue handshake from requester g, ptr SHALL become (g+1) mod N_REQ next cycle; otherwise ptr holds.
REQ-018 When |req_valid=1 and fifo_enq_ready=0 (FIFO full), drop_cnt SHALL increment by 1, saturating at 255.
REQ-019 Drain FSM states: IDLE, COUNT, WAIT.
REQ-020 IDLE -> COUNT when drain_en=1, with tick counter cleared to 0.
REQ-021 COUNT: counter increments each cycle; at DRAIN_CNT_MAX-1 -> WAIT, counter cleared.
REQ-022 WAIT: fifo_deq_ready=1; on fifo_deq_valid=1 (handshake) -> COUNT; if FIFO empty, remains WAIT until data arrives (tick never lost).
REQ-023 fifo_deq_ready SHALL be 1 only in WAIT; exactly one entry dequeued per WAIT visit.
REQ-024 drain_en=0 in any state SHALL force IDLE next cycle, counter cleared, fifo_deq_ready=0 that same cycle (combinationally gated).
REQ-025 On dequeue handshake, out_data SHALL load fifo_deq_data and out_valid SHALL pulse 1 the following cycle only; out_data holds otherwise.
REQ-026 Latency: dequeue handshake to out_valid = 1 cycle; drain_en rise to first fifo_deq_ready = DRAIN_CNT_MAX+1 cycles.
REQ-027 Enqueue and dequeue handshakes in the same cycle SHALL both proceed independently.
REQ-028 Counter width SHALL be $clog2(DRAIN_CNT_MAX) bits minimum; no overflow possible.

Reset
REQ-029 rst=1 SHALL asynchronously set ptr=0, drain FSM=IDLE, tick counter=0, drop_cnt=0, out_data=0, out_valid=0.
REQ-030 Reset mid-operation SHALL abort WAIT immediately (fifo_deq_ready=0 while rst=1); no partial handshake recorded.
REQ-031 First rising edge after rst deasserts SHALL evaluate normally with reset state.

Verification
REQ-032 Fairness: req_valid=4'b1111, fifo_enq_ready=1 for 8 cycles -> req_ready sequence 0001,0010,0100,1000,0001,... with data of each requester on fifo_enq_data.
REQ-033 Full stall: req_valid=4'b0100, fifo_enq_ready=0 for 300 cycles -> req_ready=0, ptr unchanged, drop_cnt=255 (saturated).
REQ-034 Drain timing (DRAIN_CNT_MAX=10): FIFO holds 3,7; drain_en=1 -> fifo_deq_ready at cycle 11, out_data=3 with out_valid pulse, next fifo_deq_ready 11 cycles later, out_data=7.
REQ-035 Empty wait: drain_en=1, FIFO empty for 50 cycles then enqueue 5 -> fifo_deq_ready held high throughout, 5 dequeued in the cycle it appears at deq, out_data=5 next cycle.
REQ-036 Abort: drain_en dropped while in WAIT -> fifo_deq_ready=0 same cycle, FSM IDLE, no out_valid; rst asserted mid-COUNT -> all outputs at reset values before next edge.
